// File: rtl/sseg_display_arbiter.sv
// sseg_display_arbiter: round-robin sharing of one 8-digit seven-segment display with min hold and blank gap.
// Optional SSEG_ARB_PRIORITY_EN makes requester 0 high priority.
module sseg_display_arbiter #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] an_in,
  input  logic [31:0] sseg_in,
  output logic [3:0]  gnt,
  output logic [7:0]  an,
  output logic [7:0]  sseg
);
  localparam int TW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [1:0] IDLE = 2'd0, OWN = 2'd1, BLANK = 2'd2;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LD = BW'(BLANK_CYCLES - 1);

  logic [1:0]    state_q, state_d, last_q, last_d, win, idx;
  logic [3:0]    gnt_q, gnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [7:0]    an_q, an_d, sseg_q, sseg_d;
  logic          win_vld, drop, do_arb;

  // Later iterations override earlier ones, so the nearest requester after last wins.
  always_comb begin
    win = last_q;
    idx = last_q;
    win_vld = |req;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) win = idx;
    end
`ifdef SSEG_ARB_PRIORITY_EN
    if (req[0]) win = 2'd0;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    timer_d = timer_q;
    blank_d = blank_q;
    do_arb  = 1'b0;
    drop    = !req[last_q] || (timer_q == '0 && |(req & ~(4'b1 << last_q)));
`ifdef SSEG_ARB_PRIORITY_EN
    drop    = drop || (last_q != 2'd0 && req[0]);
`endif
    case (state_q)
      IDLE: do_arb = 1'b1;
      OWN: begin
        state_d = drop ? BLANK : OWN;
        gnt_d   = drop ? 4'b0 : gnt_q;
        blank_d = drop ? BLANK_LD : blank_q;
        timer_d = drop ? timer_q : (timer_q != '0 ? timer_q - 1'b1 : HOLD_LD);
      end
      BLANK: begin
        do_arb  = blank_q == '0;
        blank_d = blank_q != '0 ? blank_q - 1'b1 : blank_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0;
      end
    endcase
    if (do_arb) begin
      state_d = win_vld ? OWN : IDLE;
      gnt_d   = win_vld ? 4'b1 << win : 4'b0;
      last_d  = win_vld ? win : last_q;
      timer_d = win_vld ? HOLD_LD : timer_q;
    end
  end

  // Pass-through of the current owner's pattern; display data lags gnt by one cycle.
  always_comb begin
    an_d   = 8'hFF;
    sseg_d = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      if (gnt_q[i]) begin
        an_d   = an_in[8*i +: 8];
        sseg_d = sseg_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0;
      last_q  <= 2'd3;
      timer_q <= '0;
      blank_q <= '0;
      an_q    <= 8'hFF;
      sseg_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
    end
  end

  assign gnt  = gnt_q;
  assign an   = an_q;
  assign sseg = sseg_q;
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// tb_sseg_display_arbiter: directed and random stimulus against a cycle-level ownership model.
module tb_sseg_display_arbiter;
  localparam int HOLD = 8, BLANK = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] an_in = 32'h0, sseg_in = 32'h0;
  logic [3:0]  gnt;
  logic [7:0]  an, sseg;
  int checks = 0, errors = 0;

  int m_owner = -1, m_last = 3, m_age = 0, m_gap = 0;
  logic [7:0] m_an = 8'hFF, m_sseg = 8'hFF;

  always #5 clk = ~clk;

  sseg_display_arbiter #(.HOLD_CYCLES(HOLD), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset), .req(req), .an_in(an_in), .sseg_in(sseg_in),
    .gnt(gnt), .an(an), .sseg(sseg)
  );

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef SSEG_ARB_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (last + k) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_age = 0; m_gap = 0;
    m_an = 8'hFF; m_sseg = 8'hFF;
  endtask

  // Owner age counts cycles since grant/renewal; the gap counts blank cycles already shown.
  task automatic model_edge();
    bit do_arb, expired, others, leave;
    int w;
    do_arb = 0;
    m_an   = m_owner >= 0 ? an_in[m_owner*8 +: 8] : 8'hFF;
    m_sseg = m_owner >= 0 ? sseg_in[m_owner*8 +: 8] : 8'hFF;
    if (m_gap > 0) begin
      if (m_gap == BLANK) do_arb = 1; else m_gap++;
    end else if (m_owner >= 0) begin
      expired = m_age >= HOLD - 1;
      others  = (req & ~(4'b1 << m_owner)) != 4'b0;
      leave   = !req[m_owner] || (expired && others);
`ifdef SSEG_ARB_PRIORITY_EN
      leave   = leave || (m_owner != 0 && req[0]);
`endif
      if (leave) begin
        m_owner = -1;
        m_gap = 1;
      end else if (!expired) m_age++;
      else m_age = 0;
    end else do_arb = 1;
    if (do_arb) begin
      w = pick(req, m_last);
      m_gap = 0;
      m_owner = w;
      if (w >= 0) begin
        m_last = w;
        m_age = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input bit rnd);
    req = r;
    if (rnd) begin
      an_in = $urandom;
      sseg_in = $urandom;
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", {4'b0, gnt}, m_owner >= 0 ? 8'(4'b1 << m_owner) : 8'h00);
    chk("an", an, m_an);
    chk("sseg", sseg, m_sseg);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_gnt", {4'b0, gnt}, 8'h00);
    chk("rst_an", an, 8'hFF);
    chk("rst_sseg", sseg, 8'hFF);
    model_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    do_reset();
    step(4'b1001, 1);
    chk("t1_first_gnt", {4'b0, gnt}, 8'h01);
    repeat (3) step(4'b1001, 1);
    do_reset();
    an_in = {8'h12, 8'hFE, 16'h3456};
    sseg_in = {8'h78, 8'h9C, 16'hABCD};
    repeat (40) step(4'b0100, 0);
    chk("t2_gnt", {4'b0, gnt}, 8'h04);
    chk("t2_an", an, 8'hFE);
    chk("t2_sseg", sseg, 8'h9C);
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(4'b0011, 1);
      if (i == 8) chk("t3_own0", {4'b0, gnt}, 8'h01);
      if (i == 10) chk("t3_gap", an, 8'hFF);
      if (i == 11) chk("t3_own1", {4'b0, gnt}, 8'h02);
    end
    do_reset();
    repeat (3) step(4'b1100, 1);
    repeat (8) step(4'b1000, 1);
    do_reset();
    repeat (3) step(4'b0010, 1);
    repeat (14) step(4'b0011, 1);
    do_reset();
    repeat (2) step(4'b1000, 1);
    step(4'b1001, 1);
`ifdef SSEG_ARB_PRIORITY_EN
    chk("t6_preempt", {4'b0, gnt}, 8'h00);
`else
    chk("t6_hold", {4'b0, gnt}, 8'h08);
`endif
    repeat (14) step(4'b1001, 1);
    do_reset();
    r = 4'($urandom);
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      step(r, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sseg_display_arbiter.md
Name: sseg_display_arbiter

Overview:
- Shares the single 8-digit seven-segment display between four pattern sources, e.g. the rotating-square generator, a counter display and a status display.
- Round-robin arbitration with a minimum hold time per owner.
- A blanking gap on every handover prevents ghosting.
- Sits between the pattern generators and the board-level an/sseg pins.

Parameters:
- HOLD_CYCLES, 50_000_000: minimum ownership time in clk cycles (0.5 s at 100 MHz); must be at least 1.
- BLANK_CYCLES, 2: display-off cycles between owners; must be at least 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  display request, one bit per requester
- an_in  input  32  digit enables, active-low; bits [8i+7:8i] belong to requester i
- sseg_in  input  32  segment patterns, active-low; bits [8i+7:8i] belong to requester i
- gnt  output  4  one-hot grant, or all-zero
- an  output  8  digit enables to the display, active-low
- sseg  output  8  segments to the display, active-low

Behaviour:
- Reset, applied asynchronously:
  - state = IDLE, gnt = 0, an = 8'hFF, sseg = 8'hFF (display dark).
  - Hold timer = 0, blank counter = 0.
  - Round-robin pointer last = 3, so requester 0 wins first.
- All outputs are registered. Reset mid-operation drops gnt immediately.
- States: IDLE, OWN, BLANK.
- Arbitration rule, applied in IDLE and at BLANK exit:
  - Winner is the first set req bit searching last+1, last+2, last+3, last+4 (mod 4).
  - On a win: gnt <= onehot(winner), last <= winner, timer <= HOLD_CYCLES-1, state <= OWN.
  - No req set: stay in or go to IDLE, gnt = 0.
- IDLE: arbitrates every cycle. A req sampled high at edge k gives gnt at edge k.
- OWN, owner o, evaluated every edge in priority order:
  1. req[o] = 0: gnt <= 0, blank <= BLANK_CYCLES-1, state <= BLANK. The owner may release before the hold expires.
  2. timer != 0: timer decrements and gnt holds.
  3. timer = 0 and any req[j] set with j != o: go to BLANK as in rule 1.
  4. timer = 0 and only req[o] set: timer <= HOLD_CYCLES-1 and stay. No gap, no gnt glitch.
- BLANK:
  - gnt = 0. The blank counter decrements.
  - At the edge where blank = 0, apply the arbitration rule directly. The gap is exactly BLANK_CYCLES cycles.
- Data path:
  - At every edge: if gnt = onehot(i), an <= an_in[8i+7:8i] and sseg <= sseg_in[8i+7:8i]; else an <= 8'hFF and sseg <= 8'hFF.
  - Display data therefore lags gnt by one cycle.
  - The block passes source data through unchanged, with no latching of the pattern at grant time.
- Simultaneous events:
  - Owner drop and timer expiry on the same edge: treated as drop (rule 1).
  - Requests arriving during BLANK are considered at BLANK exit.
- Counter widths: $clog2 of the parameter value, minimum 1 bit. Timers never wrap; they stop at 0.
- Invariant: gnt is always one-hot or zero.

Optional Feature:
- Macro: SSEG_ARB_PRIORITY_EN.
- Defined: requester 0 is high priority.
  - In OWN with o != 0, req[0] = 1 forces BLANK at the next edge regardless of timer.
  - Arbitration at BLANK exit or in IDLE grants 0 whenever req[0] = 1.
  - While requester 0 owns, hold expiry still rotates ownership normally (rule 3).
- Undefined: pure round-robin as above. req[0] has no special treatment.

Test Plan (HOLD_CYCLES=8, BLANK_CYCLES=2 unless noted):
1. Reset: assert reset mid-cycle in OWN -> gnt=0000, an=FF, sseg=FF immediately, without waiting for a clk edge. After release with req=1001 -> gnt=0001, pointer started at 3.
2. Single requester: req=0100 held for 40 cycles, an_in[23:16]=8'hFE, sseg_in[23:16]=8'h9C -> gnt=0100 continuously with no gap. an=FE and sseg=9C from one cycle after gnt onward.
3. Rotation: req=0011 from IDLE -> repeating pattern of gnt=0001 x8, 0000 x2, 0010 x8, 0000 x2. an=FF throughout each gap.
4. Early release: owner 2 drops req after 3 granted cycles while req[3]=1 -> gnt=0000 at the next edge, 2 blank cycles, then gnt=1000.
5. Late join: owner 1 alone, req[0] rises at timer=5 -> owner 1 keeps gnt until timer reaches 0, then gap of 2, then gnt=0001 (pointer wraps 1→2→3→0 past idle requesters).
6. With SSEG_ARB_PRIORITY_EN defined: owner 3 at timer=6, req[0] rises -> gnt=0000 at the next edge, 2 blank cycles, gnt=0001. The same stimulus without the macro holds owner 3 until timer reaches 0.
